aes_bus_frontend: RTL
=====================

# aes_bus_frontend

Parametrised byte-serial bus front-end for the AES core. It receives command frames on a narrow data bus: address beats first, then payload beats. It filters each frame on destination ID, presents one wide request to the core, streams read results back over the same narrow bus, and returns an acknowledgement tagged with the requester's ID. It replaces the fixed tie-offs of the previous top-level mapping: the address is time-multiplexed, and `encdec` is carried per frame.

## Interface
Parameters:
- `BUS_W`, 8, data bus width in bits.
- `ADDR_BEATS`, 3, address beats per frame (≥1); address width `AW = BUS_W*ADDR_BEATS`.
- `BLOCK_BEATS`, 16, payload/result beats; block width `BW = BUS_W*BLOCK_BEATS`.
- `ID_W`, 2, source/destination ID width.
- `MY_ID`, 0, this module's destination ID.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1: clock.
  - `rst_n` in 1: asynchronous active-low reset.
- Inbound bus:
  - `data_in` in BUS_W: inbound beat.
  - `valid_in` in 1: inbound beat valid.
  - `ready_in` out 1: module accepts a beat.
- Frame sideband, sampled on the first beat only:
  - `opcode` in 2: frame opcode.
  - `source_id` in ID_W: requester ID.
  - `dest_id` in ID_W: target ID.
  - `encdec` in 1: 0 = encrypt, 1 = decrypt.
- Outbound bus:
  - `data_out` out BUS_W: result beat.
  - `data_valid` out 1: result beat valid.
  - `data_ready` in 1: downstream accepts a result beat.
- Acknowledgement:
  - `ack_valid` out 1: acknowledgement pending.
  - `ack_ready` in 1: acknowledgement consumed.
  - `module_source_id` out ID_W: latched `source_id` of the frame being acked.
- Core request:
  - `core_valid` out 1: request to core.
  - `core_ready` in 1: core accepts request.
  - `core_opcode` out 2.
  - `core_encdec` out 1.
  - `core_addr` out AW.
  - `core_block` out BW.
- Core result:
  - `core_res_valid` in 1: result from core.
  - `core_res_ready` out 1: module accepts result.
  - `core_res_block` in BW.

## Operation
- A handshake occurs on a rising edge where `valid && ready` are both high, on every channel.
- Opcodes:
  - KEY=0: address + payload; payload is the key.
  - TEXT=1: address + payload; payload is the text block.
  - START=2: address only.
  - READ=3: address only; the result is returned on the outbound bus.
- FSM states: IDLE, ADDR, PAYLOAD, ISSUE, WAIT_RES, SEND, ACK, DROP.
- IDLE:
  - `ready_in=1`.
  - On the first beat: latch the sideband, set `match = (dest_id==MY_ID)`, store the beat as the address MSB beat, and set beat count to 1.
  - Next state is ADDR. If `ADDR_BEATS==1`, skip ADDR and proceed as if leaving ADDR.
- ADDR:
  - Shift in the remaining address beats MSB-first.
  - After the last address beat: KEY/TEXT go to PAYLOAD; START/READ go to ISSUE if `match`, else IDLE.
- PAYLOAD:
  - Shift in `BLOCK_BEATS` beats; beat 0 lands in `core_block[BW-1 -: BUS_W]`.
  - After the last beat: ISSUE if `match`, else IDLE. A non-matching frame is fully consumed and discarded: no core request, no ack.
- ISSUE:
  - `core_valid=1` with all `core_*` fields held stable until `core_ready`.
  - On the core handshake: READ goes to WAIT_RES; all other opcodes go to ACK.
- WAIT_RES:
  - `core_res_ready=1`.
  - On the result handshake, capture `core_res_block` and go to SEND.
- SEND:
  - `data_valid=1`, `data_out` = MSB beat of the captured block.
  - On each outbound handshake, shift left by `BUS_W`.
  - After `BLOCK_BEATS` handshakes go to ACK.
- ACK:
  - `ack_valid=1`, `module_source_id` = latched `source_id`.
  - On `ack_ready`, go to IDLE.
- `ready_in=0` in ISSUE, WAIT_RES, SEND and ACK. No new frame is accepted until the ack completes.
- `data_out` is 0 whenever `data_valid=0`. `module_source_id` is 0 whenever `ack_valid=0`.
- Sideband changes after the first beat are ignored.
- `valid_in` dropping mid-frame stalls the frame indefinitely. There is no timeout.

## Timing
- Reset values:
  - State IDLE; all counters and shift registers 0.
  - All outputs 0, including `ready_in`.
  - `ready_in` rises on the first `clk` edge after `rst_n` deasserts.
- Reset asserted mid-frame aborts immediately. Partial data is discarded, and no ack is issued for the aborted frame.
- Last payload beat at edge N: `core_valid` is high in cycle N+1.
- Core handshake at edge M (non-READ): `ack_valid` is high in cycle M+1.
- Result handshake at edge R: `data_valid` is high in cycle R+1.
- The last outbound handshake at edge S gives `ack_valid` in cycle S+1.
- Ack handshake at edge A: `ready_in` is high in cycle A+1. The next first beat can be accepted at edge A+1.
- Back-to-back beats are accepted every cycle in ADDR and PAYLOAD, and emitted every cycle in SEND.
- Minimum KEY/TEXT frame turnaround: `ADDR_BEATS + BLOCK_BEATS + 2` cycles, with `core_ready` and `ack_ready` tied high.

## Structure
- Package `aes_bus_pkg`:
  - opcode constants OP_KEY, OP_TEXT, OP_START, OP_READ;
  - the state enum;
  - function `op_has_payload(opcode)`.
- Sub-module `bus_shift_reg` (params `BUS_W`, `BEATS`): parallel load, serial shift-in/shift-out MSB-first, beat counter with `last` flag.
  - Instantiated three times: address, inbound payload, outbound result.

## Test plan
- Reset: all outputs 0 during reset. `ready_in=1` one cycle after release. Assert reset mid-PAYLOAD after 7 beats → IDLE. A following full frame completes correctly.
- KEY frame, `dest=MY_ID`, `src=2`, addr beats 12,34,56, payload 00..0F → `core_addr=0x123456`, `core_block=0x000102…0F`, `core_opcode=0`. After `core_ready`: `ack_valid=1`, `module_source_id=2`.
- Backpressure: `core_ready` held low 5 cycles → `core_valid` stays 1, fields stable, `ready_in=0` throughout.
- READ frame with `encdec=1` → `core_encdec=1`. Core returns `0xA5A5…A5` with the LSB beat 0x3C → 16 beats MSB-first, ending with 0x3C. `data_ready` toggled every cycle is honoured. Ack follows the 16th beat.
- Foreign dest (`dest≠MY_ID`) TEXT frame → all 19 beats accepted, no `core_valid`, no `ack_valid`. An immediately following matching START frame is issued normally.
- `ADDR_BEATS=1`, `BUS_W=16` build: START frame → `core_valid` one cycle after the single beat.

Source files
------------

// File: rtl/aes_bus_pkg.sv
// Shared opcodes, FSM state encoding and opcode helpers for the AES bus front-end.
`timescale 1ns/1ps
package aes_bus_pkg;

   localparam logic [1:0] OP_KEY   = 2'd0;
   localparam logic [1:0] OP_TEXT  = 2'd1;
   localparam logic [1:0] OP_START = 2'd2;
   localparam logic [1:0] OP_READ  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_PAYLOAD,
      ST_ISSUE,
      ST_WAIT_RES,
      ST_SEND,
      ST_ACK,
      ST_DROP
   } state_e;

   // KEY and TEXT frames carry a payload block after the address beats.
   function automatic logic op_has_payload(input logic [1:0] opcode);
      return (opcode == OP_KEY) || (opcode == OP_TEXT);
   endfunction

endpackage

// File: rtl/bus_shift_reg.sv
// MSB-first beat shift register with parallel load and a wrapping beat counter.
`timescale 1ns/1ps
module bus_shift_reg #(
   parameter int BUS_W = 8,
   parameter int BEATS = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   load_i,
   input  logic [BUS_W*BEATS-1:0] load_data_i,
   input  logic                   shift_i,
   input  logic [BUS_W-1:0]       shift_data_i,
   output logic [BUS_W*BEATS-1:0] data_o,
   output logic                   last_o
);

   localparam int W  = BUS_W * BEATS;
   localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic [W-1:0]  data_q, data_d, shifted;
   logic [CW-1:0] cnt_q, cnt_d;

   // A single-beat register simply replaces its content on every shift.
   generate
      if (BEATS == 1) begin : g_one
         assign shifted = shift_data_i;
      end else begin : g_many
         assign shifted = {data_q[W-BUS_W-1:0], shift_data_i};
      end
   endgenerate

   // last_o flags that the shift happening this cycle completes the block.
   assign last_o = (cnt_q == CW'(BEATS - 1));
   assign data_o = data_q;

   // Load restarts the beat count; a shift advances it and wraps after the last beat.
   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      if (load_i) begin
         data_d = load_data_i;
         cnt_d  = '0;
      end else if (shift_i) begin
         data_d = shifted;
         cnt_d  = last_o ? '0 : cnt_q + 1'b1;
      end
   end

   // Register content and beat count.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/aes_bus_frontend.sv
// Narrow command-bus front-end: collects address/payload beats, issues one wide
// core request, streams read results back and acknowledges the requester.
`timescale 1ns/1ps
module aes_bus_frontend
   import aes_bus_pkg::*;
#(
   parameter int BUS_W       = 8,
   parameter int ADDR_BEATS  = 3,
   parameter int BLOCK_BEATS = 16,
   parameter int ID_W        = 2,
   parameter int MY_ID       = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [BUS_W-1:0]             data_in,
   input  logic                         valid_in,
   output logic                         ready_in,
   input  logic [1:0]                   opcode,
   input  logic [ID_W-1:0]              source_id,
   input  logic [ID_W-1:0]              dest_id,
   input  logic                         encdec,
   output logic [BUS_W-1:0]             data_out,
   output logic                         data_valid,
   input  logic                         data_ready,
   output logic                         ack_valid,
   input  logic                         ack_ready,
   output logic [ID_W-1:0]              module_source_id,
   output logic                         core_valid,
   input  logic                         core_ready,
   output logic [1:0]                   core_opcode,
   output logic                         core_encdec,
   output logic [BUS_W*ADDR_BEATS-1:0]  core_addr,
   output logic [BUS_W*BLOCK_BEATS-1:0] core_block,
   input  logic                         core_res_valid,
   output logic                         core_res_ready,
   input  logic [BUS_W*BLOCK_BEATS-1:0] core_res_block
);

   localparam int BW = BUS_W * BLOCK_BEATS;

   state_e          state_q, state_d;
   logic            init_q;
   logic [1:0]      op_q, op_d;
   logic [ID_W-1:0] src_q, src_d;
   logic            enc_q, enc_d;
   logic            match_q, match_d;

   logic            dest_match;
   logic            side_latch, addr_shift, pay_shift, res_load, res_shift;
   logic            addr_last, pay_last, res_last;
   logic [BW-1:0]   res_data;
   logic            unused_res;

   assign dest_match = (dest_id == ID_W'(MY_ID));

   // Where a frame goes once its address is complete.
   function automatic state_e after_addr(input logic [1:0] op, input logic m);
      if (op_has_payload(op)) return m ? ST_PAYLOAD : ST_DROP;
      return m ? ST_ISSUE : ST_IDLE;
   endfunction

   // Next-state and handshake outputs; ready_in waits one edge after reset release.
   always_comb begin
      state_d        = state_q;
      ready_in       = 1'b0;
      core_valid     = 1'b0;
      core_res_ready = 1'b0;
      data_valid     = 1'b0;
      ack_valid      = 1'b0;
      side_latch     = 1'b0;
      addr_shift     = 1'b0;
      pay_shift      = 1'b0;
      res_load       = 1'b0;
      res_shift      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ready_in = init_q;
            if (valid_in && init_q) begin
               side_latch = 1'b1;
               addr_shift = 1'b1;
               state_d    = addr_last ? after_addr(opcode, dest_match) : ST_ADDR;
            end
         end
         ST_ADDR: begin
            ready_in = 1'b1;
            if (valid_in) begin
               addr_shift = 1'b1;
               if (addr_last) state_d = after_addr(op_q, match_q);
            end
         end
         ST_PAYLOAD, ST_DROP: begin
            ready_in = 1'b1;
            if (valid_in) begin
               pay_shift = 1'b1;
               if (pay_last) state_d = (state_q == ST_PAYLOAD) ? ST_ISSUE : ST_IDLE;
            end
         end
         ST_ISSUE: begin
            core_valid = 1'b1;
            if (core_ready) state_d = (op_q == OP_READ) ? ST_WAIT_RES : ST_ACK;
         end
         ST_WAIT_RES: begin
            core_res_ready = 1'b1;
            if (core_res_valid) begin
               res_load = 1'b1;
               state_d  = ST_SEND;
            end
         end
         ST_SEND: begin
            data_valid = 1'b1;
            if (data_ready) begin
               res_shift = 1'b1;
               if (res_last) state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            ack_valid = 1'b1;
            if (ack_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sideband is captured on the first beat only and held for the whole frame.
   always_comb begin
      op_d    = op_q;
      src_d   = src_q;
      enc_d   = enc_q;
      match_d = match_q;
      if (side_latch) begin
         op_d    = opcode;
         src_d   = source_id;
         enc_d   = encdec;
         match_d = dest_match;
      end
   end

   // State, ready gate and latched sideband.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         init_q  <= 1'b0;
         op_q    <= '0;
         src_q   <= '0;
         enc_q   <= 1'b0;
         match_q <= 1'b0;
      end else begin
         state_q <= state_d;
         init_q  <= 1'b1;
         op_q    <= op_d;
         src_q   <= src_d;
         enc_q   <= enc_d;
         match_q <= match_d;
      end
   end

   bus_shift_reg #(.BUS_W(BUS_W), .BEATS(ADDR_BEATS)) u_addr (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .load_i       (1'b0),
      .load_data_i  ('0),
      .shift_i      (addr_shift),
      .shift_data_i (data_in),
      .data_o       (core_addr),
      .last_o       (addr_last)
   );

   bus_shift_reg #(.BUS_W(BUS_W), .BEATS(BLOCK_BEATS)) u_payload (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .load_i       (1'b0),
      .load_data_i  ('0),
      .shift_i      (pay_shift),
      .shift_data_i (data_in),
      .data_o       (core_block),
      .last_o       (pay_last)
   );

   bus_shift_reg #(.BUS_W(BUS_W), .BEATS(BLOCK_BEATS)) u_result (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .load_i       (res_load),
      .load_data_i  (core_res_block),
      .shift_i      (res_shift),
      .shift_data_i ('0),
      .data_o       (res_data),
      .last_o       (res_last)
   );

   // Lower result bits reach data_out only by being shifted up into the MSB beat.
   assign unused_res = ^res_data;

   assign core_opcode      = op_q;
   assign core_encdec      = enc_q;
   assign data_out         = data_valid ? res_data[BW-1 -: BUS_W] : '0;
   assign module_source_id = ack_valid ? src_q : '0;

endmodule
